// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU sequencing controller and its register file.
//   DATA_W      - width of the operand registers and of the ALU result
//   OP_*        - ALU opcodes; the controller forwards them to the ALU without decoding
//   state_t     - controller FSM states
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DATA_W operand register file.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset (clears every entry)
//   ld_en, ld_addr, ld_data     - direct load write port
//   wb_en, wb_addr, wb_data     - result writeback write port
//   rd_addr_a/rd_data_a         - asynchronous read port A
//   rd_addr_b/rd_data_b         - asynchronous read port B
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREG = 4,
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [NREG];

  // The writeback assignment comes last so it overrides a load to the same
  // entry in the same cycle; loads to other entries still land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        regs[ld_addr] <= ld_data;
      end
      if (wb_en) begin
        regs[wb_addr] <= wb_data;
      end
    end
  end

  // Reads see pre-edge contents only; a same-cycle write is not bypassed.
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one instruction at a time through an external
// combinational ALU and writes the result back into the local register file.
// Ports:
//   clk, rst                              - clock, asynchronous active-high reset
//   instr_valid/instr_ready               - instruction handshake
//   instr_op, instr_ra, instr_rb, instr_rd - opcode, source A/B, destination index
//   ld_en, ld_addr, ld_data               - direct register-file load, usable in any state
//   alu_a, alu_b, alu_opcode              - registered operands/opcode to the ALU
//   alu_out                               - ALU result
//   res_valid/res_ready                   - result handshake
//   res_data, res_rd, res_zero            - captured result, its destination, result==0
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int NREG = 4,
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [AW-1:0]     instr_ra,
  input  logic [AW-1:0]     instr_rb,
  input  logic [AW-1:0]     instr_rd,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [AW-1:0]     res_rd,
  output logic              res_zero
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              wb_en;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  alu_regfile #(.NREG(NREG)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_en     (wb_en),
    .wb_addr   (res_rd),
    .wb_data   (res_data),
    .rd_addr_a (instr_ra),
    .rd_data_a (rf_a),
    .rd_addr_b (instr_rb),
    .rd_data_b (rf_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign accept = instr_valid & instr_ready;
  assign wb_en  = res_valid & res_ready;

  // Operands and destination are only sampled on an accept, so they stay
  // put while the ALU works and while the result waits for res_ready.
  // The result is captured in EXEC and then frozen through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= OP_ZERO;
      res_rd     <= '0;
      res_data   <= '0;
      res_zero   <= 1'b1;
    end else begin
      if (accept) begin
        alu_a      <= rf_a;
        alu_b      <= rf_b;
        alu_opcode <= instr_op;
        res_rd     <= instr_rd;
      end
      if (state == ST_EXEC) begin
        res_data <= alu_out;
        res_zero <= (alu_out == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl. The bench plays the
// role of the parent and supplies the combinational ALU.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] rd;
    logic       zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_ra;
  logic [1:0] instr_rb;
  logic [1:0] instr_rd;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_rd;
  logic       res_zero;

  exp_t       sb[$];
  logic [7:0] model_reg [4];
  logic [7:0] sweep_exp [8];
  int         vectors = 0;
  int         miscompares = 0;
  time        accept_time;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NREG(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_rd    (instr_rd),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .res_zero    (res_zero)
  );

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      OP_NOT:  return ~a;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_MUL:  return p[7:0];
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_out = ref_alu(alu_opcode, alu_a, alu_b);

  // Pops the scoreboard on every result handshake and mirrors the writeback
  // into the model register file.
  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL sb_unexpected: got data=%h rd=%0d with no instruction outstanding", res_data, res_rd);
        end else begin
          e = sb.pop_front();
          if ({res_data, res_rd, res_zero} !== {e.data, e.rd, e.zero}) begin
            miscompares++;
            $display("[TB] FAIL sb_result: got data=%h rd=%0d zero=%b, want data=%h rd=%0d zero=%b",
                     res_data, res_rd, res_zero, e.data, e.rd, e.zero);
          end
          model_reg[e.rd] = e.data;
        end
      end
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    model_reg[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Offers one instruction and returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr_op = op;
    instr_ra = ra;
    instr_rb = rb;
    instr_rd = rd;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        e.data = ref_alu(op, model_reg[ra], model_reg[rb]);
        e.rd = rd;
        e.zero = (e.data == 8'h00);
        sb.push_back(e);
        @(posedge clk);
        accept_time = $time;
        #1;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    instr_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL issue_timeout: instr_ready never seen, got ready=%b want 1", instr_ready);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && instr_ready) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
    end
  endtask

  task automatic wait_res_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL res_valid_timeout: got res_valid=%b want 1", res_valid);
    end
  endtask

  // Reads a register by issuing OR rX,rX -> rX, which leaves it unchanged.
  task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
    issue(OP_OR, idx, idx, idx);
    val = alu_a;
    drain();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    vectors++;
    if ({instr_ready, res_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL reset_hs: got ready=%b valid=%b want ready=1 valid=0", instr_ready, res_valid);
    end
    vectors++;
    if ({alu_a, alu_b, alu_opcode} !== {8'h00, 8'h00, 3'b111}) begin
      miscompares++;
      $display("[TB] FAIL reset_alu: got a=%h b=%h op=%b want a=00 b=00 op=111", alu_a, alu_b, alu_opcode);
    end
    vectors++;
    if ({res_data, res_rd, res_zero} !== {8'h00, 2'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_res: got data=%h rd=%0d zero=%b want data=00 rd=0 zero=1", res_data, res_rd, res_zero);
    end
    // Instruction offered as reset drops must be taken on the very next edge.
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b1;
    instr_op = OP_ADD;
    instr_ra = 2'd0;
    instr_rb = 2'd0;
    instr_rd = 2'd0;
    e.data = 8'h00;
    e.rd = 2'd0;
    e.zero = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    vectors++;
    if ({instr_ready, alu_opcode} !== {1'b0, OP_ADD}) begin
      miscompares++;
      $display("[TB] FAIL first_accept: got ready=%b op=%b want ready=0 op=%b", instr_ready, alu_opcode, OP_ADD);
    end
    drain();
  endtask

  task automatic test_add();
    logic [7:0] v;
    load(2'd0, 8'h05);
    load(2'd1, 8'h03);
    issue(OP_ADD, 2'd0, 2'd1, 2'd2);
    vectors++;
    if ({alu_a, alu_b, alu_opcode} !== {8'h05, 8'h03, OP_ADD}) begin
      miscompares++;
      $display("[TB] FAIL add_operands: got a=%h b=%h op=%b want a=05 b=03 op=%b", alu_a, alu_b, alu_opcode, OP_ADD);
    end
    @(negedge clk);
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_exec_valid: got res_valid=%b want 0", res_valid);
    end
    @(negedge clk);
    vectors++;
    if ({res_valid, res_data, res_zero, res_rd} !== {1'b1, 8'h08, 1'b0, 2'd2}) begin
      miscompares++;
      $display("[TB] FAIL add_latency: got valid=%b data=%h zero=%b rd=%0d want valid=1 data=08 zero=0 rd=2",
               res_valid, res_data, res_zero, res_rd);
    end
    drain();
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h08) begin
      miscompares++;
      $display("[TB] FAIL add_writeback: got r2=%h want 08", v);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    load(2'd3, 8'h55);
    load(2'd0, 8'hFF);
    load(2'd1, 8'h01);
    issue(OP_ADD, 2'd0, 2'd1, 2'd3);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({res_data, res_zero} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL wrap_result: got data=%h zero=%b want data=00 zero=1", res_data, res_zero);
    end
    drain();
    read_reg(2'd3, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL wrap_writeback: got r3=%h want 00", v);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] v;
    res_ready = 1'b0;
    load(2'd0, 8'h11);
    load(2'd1, 8'h22);
    issue(OP_XOR, 2'd0, 2'd1, 2'd1);
    wait_res_valid();
    // A competing instruction must be refused and must not disturb the ALU inputs.
    instr_valid = 1'b1;
    instr_op = OP_MUL;
    instr_ra = 2'd2;
    instr_rb = 2'd2;
    instr_rd = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({res_valid, instr_ready, res_data, res_rd, alu_opcode} !== {1'b1, 1'b0, 8'h33, 2'd1, OP_XOR}) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b data=%h rd=%0d op=%b want valid=1 ready=0 data=33 rd=1 op=%b",
                 i, res_valid, instr_ready, res_data, res_rd, alu_opcode, OP_XOR);
      end
    end
    instr_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();
    read_reg(2'd1, v);
    vectors++;
    if (v !== 8'h33) begin
      miscompares++;
      $display("[TB] FAIL hold_writeback: got r1=%h want 33", v);
    end
  endtask

  task automatic test_wb_priority();
    logic [7:0] v;
    load(2'd0, 8'h40);
    load(2'd1, 8'h02);
    res_ready = 1'b0;
    issue(OP_ADD, 2'd0, 2'd1, 2'd1);
    wait_res_valid();
    @(posedge clk); #1;
    res_ready = 1'b1;
    ld_en = 1'b1;
    ld_addr = 2'd1;
    ld_data = 8'hAA;
    model_reg[1] = 8'hAA;
    @(posedge clk); #1;
    ld_en = 1'b0;
    drain();
    read_reg(2'd1, v);
    vectors++;
    if (v !== 8'h42) begin
      miscompares++;
      $display("[TB] FAIL wb_same_index: got r1=%h want 42", v);
    end
    res_ready = 1'b0;
    issue(OP_ADD, 2'd0, 2'd0, 2'd2);
    wait_res_valid();
    @(posedge clk); #1;
    res_ready = 1'b1;
    ld_en = 1'b1;
    ld_addr = 2'd3;
    ld_data = 8'h5A;
    model_reg[3] = 8'h5A;
    @(posedge clk); #1;
    ld_en = 1'b0;
    drain();
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h80) begin
      miscompares++;
      $display("[TB] FAIL wb_diff_index_wb: got r2=%h want 80", v);
    end
    read_reg(2'd3, v);
    vectors++;
    if (v !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL wb_diff_index_ld: got r3=%h want 5a", v);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    time t1;
    logic [7:0] v;
    res_ready = 1'b1;
    load(2'd0, 8'h01);
    load(2'd1, 8'h02);
    issue(OP_ADD, 2'd0, 2'd1, 2'd2);
    t0 = accept_time;
    issue(OP_ADD, 2'd2, 2'd1, 2'd2);
    t1 = accept_time;
    vectors++;
    if (t1 - t0 !== 30) begin
      miscompares++;
      $display("[TB] FAIL b2b_spacing1: got %0t between accepts want 30", t1 - t0);
    end
    issue(OP_ADD, 2'd2, 2'd2, 2'd3);
    vectors++;
    if (accept_time - t1 !== 30) begin
      miscompares++;
      $display("[TB] FAIL b2b_spacing2: got %0t between accepts want 30", accept_time - t1);
    end
    drain();
    read_reg(2'd3, v);
    vectors++;
    if (v !== 8'h0A) begin
      miscompares++;
      $display("[TB] FAIL b2b_chain: got r3=%h want 0a", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    load(2'd2, 8'h99);
    load(2'd0, 8'h07);
    load(2'd1, 8'h01);
    issue(OP_ADD, 2'd0, 2'd1, 2'd2);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({instr_ready, res_valid, alu_a, alu_b, alu_opcode} !== {1'b1, 1'b0, 8'h00, 8'h00, 3'b111}) begin
      miscompares++;
      $display("[TB] FAIL midrst_alu: got ready=%b valid=%b a=%h b=%h op=%b want ready=1 valid=0 a=00 b=00 op=111",
               instr_ready, res_valid, alu_a, alu_b, alu_opcode);
    end
    vectors++;
    if ({res_data, res_rd, res_zero} !== {8'h00, 2'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL midrst_res: got data=%h rd=%0d zero=%b want data=00 rd=0 zero=1", res_data, res_rd, res_zero);
    end
    sb.delete();
    for (int i = 0; i < 4; i++) model_reg[i] = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({instr_ready, res_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL midrst_release: got ready=%b valid=%b want ready=1 valid=0", instr_ready, res_valid);
    end
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midrst_no_wb: got r2=%h want 00", v);
    end
    read_reg(2'd0, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midrst_rf_clear: got r0=%h want 00", v);
    end
  endtask

  task automatic test_opcode_sweep();
    res_ready = 1'b1;
    load(2'd0, 8'h0C);
    load(2'd1, 8'h0A);
    for (int op = 0; op < 8; op++) begin
      issue(3'(op), 2'd0, 2'd1, 2'd3);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({res_data, res_zero} !== {sweep_exp[op], sweep_exp[op] == 8'h00}) begin
        miscompares++;
        $display("[TB] FAIL sweep_op%0d: got data=%h zero=%b want data=%h zero=%b",
                 op, res_data, res_zero, sweep_exp[op], sweep_exp[op] == 8'h00);
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sweep_exp = '{8'hF3, 8'h0E, 8'h06, 8'h08, 8'h78, 8'h16, 8'h02, 8'h00};
    for (int i = 0; i < 4; i++) model_reg[i] = 8'h00;
    instr_valid = 1'b0;
    instr_op = 3'b000;
    instr_ra = 2'd0;
    instr_rb = 2'd0;
    instr_rd = 2'd0;
    ld_en = 1'b0;
    ld_addr = 2'd0;
    ld_data = 8'h00;
    res_ready = 1'b1;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_add();
    test_wrap();
    test_backpressure();
    test_wb_priority();
    test_back_to_back();
    test_reset_mid();
    test_opcode_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
